vga_timing_gen: RTL and testbench

- Produces the raster coordinates consumed by the pixel-colour logic: hCount, vCount and bright, plus the monitor syncs hSync and vSync.
- Divides the 100 MHz master clock down to the 25 MHz pixel rate for 640x480@60.
- Emits a one-cycle frame_tick and a free-running frame_count, which the game logic uses as its slow update strobe.
- Sits at top level, between the board clock/reset and the block/maze/pacman renderers.

---
 rtl/vga_timing_pkg.sv | 49 ++++
 rtl/vga_axis_counter.sv | 56 +++++
 rtl/vga_timing_gen.sv | 134 +++++++++++++
 tb/tb_vga_timing_gen.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing constants, window bounds and axis-region decoding.
// The region helper serves both axes of vga_axis_counter.
package vga_timing_pkg;

    localparam int H_SYNC    = 96;
    localparam int H_BACK    = 48;
    localparam int H_VISIBLE = 640;
    localparam int H_FRONT   = 16;
    localparam int V_SYNC    = 2;
    localparam int V_BACK    = 33;
    localparam int V_VISIBLE = 480;
    localparam int V_FRONT   = 10;

    localparam int H_TOTAL = H_SYNC + H_BACK + H_VISIBLE + H_FRONT;
    localparam int V_TOTAL = V_SYNC + V_BACK + V_VISIBLE + V_FRONT;

    // Renderers offset their playfields from these bounds.
    localparam int H_BRIGHT_START = H_SYNC + H_BACK;
    localparam int H_BRIGHT_END   = H_BRIGHT_START + H_VISIBLE - 1;
    localparam int V_BRIGHT_START = V_SYNC + V_BACK;
    localparam int V_BRIGHT_END   = V_BRIGHT_START + V_VISIBLE - 1;

    localparam int COUNT_W = 10;
    localparam int DIV_W   = 4;

    typedef logic [COUNT_W-1:0] count_t;

    typedef enum logic [1:0] {
        REGION_SYNC,
        REGION_BACK,
        REGION_ACTIVE,
        REGION_FRONT
    } region_e;

    function automatic region_e axis_region(input count_t c, input int sync,
                                            input int back, input int active);
        int ci;
        ci = int'(c);
        if (ci < sync) begin
            return REGION_SYNC;
        end else if (ci < sync + back) begin
            return REGION_BACK;
        end else if (ci < sync + back + active) begin
            return REGION_ACTIVE;
        end
        return REGION_FRONT;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: position counter with registered sync/active decoded from the next count.
// wrap flags the last position so the next axis can chain off it.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int SYNC   = 96,
    parameter int BACK   = 48,
    parameter int ACTIVE = 640,
    parameter int FRONT  = 16
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   advance,
    output count_t count,
    output logic   sync_n,
    output logic   active,
    output logic   wrap
);

    localparam int     TOTAL = SYNC + BACK + ACTIVE + FRONT;
    localparam count_t LAST  = count_t'(TOTAL - 1);

    count_t  count_q, count_d;
    logic    sync_n_q, sync_n_d;
    logic    active_q, active_d;
    region_e region_d;

    // Anything at or past LAST (including unreachable values) restarts at 0.
    always_comb begin
        count_d = count_q;
        if (advance) begin
            count_d = (count_q >= LAST) ? '0 : count_q + count_t'(1);
        end
        region_d = axis_region(count_d, SYNC, BACK, ACTIVE);
        sync_n_d = (region_d != REGION_SYNC);
        active_d = (region_d == REGION_ACTIVE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q  <= '0;
            sync_n_q <= 1'b0;
            active_q <= 1'b0;
        end else begin
            count_q  <= count_d;
            sync_n_q <= sync_n_d;
            active_q <= active_d;
        end
    end

    assign count  = count_q;
    assign sync_n = sync_n_q;
    assign active = active_q;
    assign wrap   = (count_q >= LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel-rate divider, h/v counters, syncs, bright window and frame strobe.
// Define VGA_RGB_REG_EN to add a registered rgb path with syncs delayed one pixel to match.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV   = 4,
    parameter int H_SYNC    = vga_timing_pkg::H_SYNC,
    parameter int H_BACK    = vga_timing_pkg::H_BACK,
    parameter int H_VISIBLE = vga_timing_pkg::H_VISIBLE,
    parameter int H_FRONT   = vga_timing_pkg::H_FRONT,
    parameter int V_SYNC    = vga_timing_pkg::V_SYNC,
    parameter int V_BACK    = vga_timing_pkg::V_BACK,
    parameter int V_VISIBLE = vga_timing_pkg::V_VISIBLE,
    parameter int V_FRONT   = vga_timing_pkg::V_FRONT
) (
    input  logic         clk,
    input  logic         rst,
    output logic         pix_en,
    output logic [9:0]   hCount,
    output logic [9:0]   vCount,
    output logic         bright,
    output logic         hSync,
    output logic         vSync,
    output logic         frame_tick,
    output logic [7:0]   frame_count
`ifdef VGA_RGB_REG_EN
    ,
    input  logic [11:0]  rgb_in,
    output logic [11:0]  rgb_out
`endif
);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic             h_sync_n, v_sync_n;
    logic             h_active, v_active;
    logic             h_wrap, v_wrap, v_advance;
    logic             frame_tick_q, frame_tick_d;
    logic [7:0]       frame_count_q, frame_count_d;

    assign pix_en    = (div_cnt_q == DIV_LAST);
    assign v_advance = pix_en & h_wrap;

    always_comb begin
        div_cnt_d     = (div_cnt_q >= DIV_LAST) ? '0 : div_cnt_q + DIV_W'(1);
        frame_tick_d  = v_advance & v_wrap;
        frame_count_d = frame_count_q + 8'(frame_tick_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_q     <= '0;
            frame_tick_q  <= 1'b0;
            frame_count_q <= '0;
        end else begin
            div_cnt_q     <= div_cnt_d;
            frame_tick_q  <= frame_tick_d;
            frame_count_q <= frame_count_d;
        end
    end

    vga_axis_counter #(
        .SYNC   (H_SYNC),
        .BACK   (H_BACK),
        .ACTIVE (H_VISIBLE),
        .FRONT  (H_FRONT)
    ) u_h_axis (
        .clk     (clk),
        .rst     (rst),
        .advance (pix_en),
        .count   (hCount),
        .sync_n  (h_sync_n),
        .active  (h_active),
        .wrap    (h_wrap)
    );

    vga_axis_counter #(
        .SYNC   (V_SYNC),
        .BACK   (V_BACK),
        .ACTIVE (V_VISIBLE),
        .FRONT  (V_FRONT)
    ) u_v_axis (
        .clk     (clk),
        .rst     (rst),
        .advance (v_advance),
        .count   (vCount),
        .sync_n  (v_sync_n),
        .active  (v_active),
        .wrap    (v_wrap)
    );

    assign bright      = h_active & v_active;
    assign frame_tick  = frame_tick_q;
    assign frame_count = frame_count_q;

`ifdef VGA_RGB_REG_EN
    logic [11:0] rgb_q, rgb_d;
    logic        h_sync_dly_q, h_sync_dly_d;
    logic        v_sync_dly_q, v_sync_dly_d;

    // Syncs take one extra pixel stage so they line up with the registered colour.
    always_comb begin
        rgb_d        = rgb_q;
        h_sync_dly_d = h_sync_dly_q;
        v_sync_dly_d = v_sync_dly_q;
        if (pix_en) begin
            rgb_d        = bright ? rgb_in : 12'h000;
            h_sync_dly_d = h_sync_n;
            v_sync_dly_d = v_sync_n;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rgb_q        <= '0;
            h_sync_dly_q <= 1'b0;
            v_sync_dly_q <= 1'b0;
        end else begin
            rgb_q        <= rgb_d;
            h_sync_dly_q <= h_sync_dly_d;
            v_sync_dly_q <= v_sync_dly_d;
        end
    end

    assign rgb_out = rgb_q;
    assign hSync   = h_sync_dly_q;
    assign vSync   = v_sync_dly_q;
`else
    assign hSync = h_sync_n;
    assign vSync = v_sync_n;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen with a shrunken raster; expected outputs come from a clock-count model.
`timescale 1ns/1ps
module tb_vga_timing_gen;

    localparam int CLK_DIV    = 2;
    localparam int H_SYNC     = 2;
    localparam int H_BACK     = 1;
    localparam int H_VISIBLE  = 4;
    localparam int H_FRONT    = 1;
    localparam int V_SYNC     = 2;
    localparam int V_BACK     = 1;
    localparam int V_VISIBLE  = 3;
    localparam int V_FRONT    = 1;
    localparam int HT         = H_SYNC + H_BACK + H_VISIBLE + H_FRONT;
    localparam int VT         = V_SYNC + V_BACK + V_VISIBLE + V_FRONT;
    localparam int FRAME_PIX  = HT * VT;
    localparam int FRAME_CLKS = FRAME_PIX * CLK_DIV;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pix_en;
    logic [9:0] hCount, vCount;
    logic       bright, hSync, vSync, frame_tick;
    logic [7:0] frame_count;
    logic [11:0] rgb_in = '0;
`ifdef VGA_RGB_REG_EN
    logic [11:0] rgb_out;
    logic [11:0] exp_rgb;
    bit          exp_hs_dly, exp_vs_dly;
`endif

    int checks = 0;
    int errors = 0;
    int k = 0;

    always #5 clk = ~clk;

    vga_timing_gen #(
        .CLK_DIV   (CLK_DIV),
        .H_SYNC    (H_SYNC),
        .H_BACK    (H_BACK),
        .H_VISIBLE (H_VISIBLE),
        .H_FRONT   (H_FRONT),
        .V_SYNC    (V_SYNC),
        .V_BACK    (V_BACK),
        .V_VISIBLE (V_VISIBLE),
        .V_FRONT   (V_FRONT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pix_en      (pix_en),
        .hCount      (hCount),
        .vCount      (vCount),
        .bright      (bright),
        .hSync       (hSync),
        .vSync       (vSync),
        .frame_tick  (frame_tick),
`ifdef VGA_RGB_REG_EN
        .rgb_in      (rgb_in),
        .rgb_out     (rgb_out),
`endif
        .frame_count (frame_count)
    );

    // Raster state after kk clock edges since reset, straight from the timing rules.
    task automatic model(input int kk, output int h, output int v, output int fc,
                         output bit pe, output bit tick, output bit hs, output bit vs,
                         output bit br);
        int pix, ph;
        pix  = kk / CLK_DIV;
        ph   = pix % FRAME_PIX;
        h    = ph % HT;
        v    = ph / HT;
        fc   = (pix / FRAME_PIX) % 256;
        pe   = (kk % CLK_DIV) == CLK_DIV - 1;
        tick = (kk % CLK_DIV == 0) && (pix > 0) && (ph == 0);
        hs   = h >= H_SYNC;
        vs   = v >= V_SYNC;
        br   = (h >= H_SYNC + H_BACK) && (h < H_SYNC + H_BACK + H_VISIBLE) &&
               (v >= V_SYNC + V_BACK) && (v < V_SYNC + V_BACK + V_VISIBLE);
    endtask

    task automatic check_field(input string tag, input logic [15:0] obs,
                               input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h (clk %0d after reset)",
                   tag, obs, exp, k);
        end
    endtask

    task automatic check_output();
        int h, v, fc;
        bit pe, tick, hs, vs, br;
        model(k, h, v, fc, pe, tick, hs, vs, br);
        check_field("pix_en", 16'(pix_en), 16'(pe));
        check_field("hCount", 16'(hCount), 16'(h));
        check_field("vCount", 16'(vCount), 16'(v));
        check_field("bright", 16'(bright), 16'(br));
        check_field("frame_tick", 16'(frame_tick), 16'(tick));
        check_field("frame_count", 16'(frame_count), 16'(fc));
`ifdef VGA_RGB_REG_EN
        check_field("hSync_dly", 16'(hSync), 16'(exp_hs_dly));
        check_field("vSync_dly", 16'(vSync), 16'(exp_vs_dly));
        check_field("rgb_out", 16'(rgb_out), 16'(exp_rgb));
`else
        check_field("hSync", 16'(hSync), 16'(hs));
        check_field("vSync", 16'(vSync), 16'(vs));
`endif
    endtask

    task automatic apply_stimulus(input bit r, input int n);
        int h, v, fc;
        bit pe, tick, hs, vs, br;
        for (int i = 0; i < n; i++) begin
            rst    = r;
            rgb_in = 12'($urandom);
            @(posedge clk);
            if (r) begin
                k = 0;
`ifdef VGA_RGB_REG_EN
                exp_rgb    = '0;
                exp_hs_dly = 1'b0;
                exp_vs_dly = 1'b0;
`endif
            end else begin
                model(k, h, v, fc, pe, tick, hs, vs, br);
`ifdef VGA_RGB_REG_EN
                if (pe) begin
                    exp_rgb    = br ? rgb_in : 12'h000;
                    exp_hs_dly = hs;
                    exp_vs_dly = vs;
                end
`endif
                k++;
            end
            #1;
            check_output();
        end
    endtask

    initial begin
        apply_stimulus(1'b1, 3);
        apply_stimulus(1'b0, 2 * FRAME_CLKS + 5);
        apply_stimulus(1'b1, 1);
        apply_stimulus(1'b0, FRAME_CLKS - 1);
        apply_stimulus(1'b1, 1);
        for (int i = 0; i < 20; i++) begin
            apply_stimulus(1'b0, $urandom_range(10, 260));
            apply_stimulus(1'b1, $urandom_range(1, 2));
        end
        apply_stimulus(1'b0, 258 * FRAME_CLKS + 40);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
